vernier_avg_accum: RTL and testbench
====================================

VERNIER_AVG_ACCUM -- requirements
Module: vernier_avg_accum

Interface
REQ-001 Parameter LOG2_N, default 8: log2 of the number of accepted samples per measurement (range 1..12).
REQ-002 Parameter MAX_REJECT, default 1023: invalid-sample count that aborts a measurement.
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  single-cycle request to begin a measurement.
REQ-006 abort  in  1  cancel the measurement in progress.
REQ-007 sample_valid  in  1  sample_ps/sample_ok are valid this cycle.
REQ-008 sample_ok  in  1  the tap code was in range (T[7] of the tap word); 0 means reject.
REQ-009 sample_ps  in  16  mapped picosecond value from the tap-to-ps map stage.
REQ-010 busy  out  1  high in ACCUM.
REQ-011 result_valid  out  1  a result is held.
REQ-012 result_ready  in  1  consumer accepts the result.
REQ-013 result_mean  out  16  rounded mean in ps.
REQ-014 result_err  out  1  measurement ended by MAX_REJECT.
REQ-015 result_rejects  out  16  rejected-sample count, saturating.
REQ-016 result_min, result_max  out  16 each  extremes of accepted samples (macro-gated, see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-018 IDLE->ACCUM on start: clear sum, accepted count, reject count and min/max.
REQ-019 In ACCUM, when sample_valid&&sample_ok, SHALL add sample_ps to a (16+LOG2_N)-bit sum with no overflow, and increment the accepted count.
REQ-020 In ACCUM, when sample_valid&&!sample_ok, SHALL increment the reject count, saturating at 16'hFFFF.
REQ-021 On the cycle the 2^LOG2_N-th sample is accepted, the next state SHALL be DONE.
REQ-022 result_mean SHALL be (sum + 2^(LOG2_N-1)) >> LOG2_N, truncated to 16 bits.
REQ-023 result_valid SHALL rise exactly one clock after the final accepted sample.
REQ-024 When the reject count reaches MAX_REJECT: go to DONE with result_err=1 and result_mean=0.
REQ-025 In DONE, outputs SHALL hold stable until result_valid&&result_ready, then go to IDLE.
REQ-026 start in ACCUM SHALL be ignored.
REQ-027 start in DONE without a handshake SHALL be ignored.
REQ-028 start coincident with the DONE handshake SHALL go directly to ACCUM with cleared accumulators.
REQ-029 abort in ACCUM SHALL return to IDLE the next cycle with no result.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 abort has priority over a sample arriving the same cycle.
REQ-032 Samples outside ACCUM SHALL be discarded; there is no backpressure on the sample side.

Reset
REQ-033 On rst_n low: state=IDLE, busy=0, result_valid=0, result_err=0, result_mean=0, result_rejects=0, result_min=16'hFFFF, result_max=0, internal sum and counters=0.
REQ-034 Reset mid-measurement SHALL discard all partial state.

Configuration
REQ-035 With VERNIER_AVG_MINMAX_EN defined: track the minimum and maximum of accepted samples; publish them in DONE.
REQ-036 Without VERNIER_AVG_MINMAX_EN: result_min=16'hFFFF and result_max=0 constant, and no min/max registers are built.

Structure
REQ-037 The shared package vernier_pkg SHALL hold the FSM state enum, PS_W=16, and the reject-counter width.
REQ-038 A sub-module vernier_avg_div (round-and-shift of the sum into result_mean) is natural; it is purely combinational and is registered in the parent.

Verification (LOG2_N=2, MAX_REJECT=3 unless noted)
REQ-039 start, samples 22,33,44,55 all ok -> result_valid one cycle after 55; mean=39, rejects=0, min=22, max=55 (macro on).
REQ-040 start, 11,ok=0,110,ok=0,22,33,44 -> mean=52, rejects=2, err=0.
REQ-041 start, three ok=0 samples -> DONE with err=1, mean=0, rejects=3.
REQ-042 Hold result_ready=0 for 10 cycles -> all outputs stable; result_ready=1 together with start -> ACCUM next cycle, counters cleared.
REQ-043 abort asserted with the third sample -> IDLE, no result_valid; a following start plus 4x1320 -> mean=1320.
REQ-044 rst_n low during ACCUM after 2 samples -> all outputs at reset values immediately; sample_valid pulses while in IDLE -> ignored.

Source files
------------

// File: rtl/vernier_pkg.sv
// ============================================================================
// Module      : vernier_pkg
// Description : Shared types and widths for the vernier averaging accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vernier_pkg;

    localparam int PS_W  = 16;
    localparam int REJ_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vernier_avg_div.sv
// ============================================================================
// Module      : vernier_avg_div
// Description : Combinational round-half-up and shift of the sample sum into a
//               PS_W-bit mean. Registered by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vernier_avg_div
    import vernier_pkg::*;
#(
    parameter int LOG2_N = 8
) (
    input  logic [PS_W+LOG2_N-1:0] i_sum,
    output logic [PS_W-1:0]        o_mean
);

    localparam int SUM_W = PS_W + LOG2_N;
    localparam logic [SUM_W:0] C_HALF = {{SUM_W{1'b0}}, 1'b1} << (LOG2_N - 1);

    // One spare bit so the rounding add cannot wrap before the shift.
    logic [SUM_W:0] w_rounded;

    assign w_rounded = {1'b0, i_sum} + C_HALF;
    assign o_mean    = PS_W'(w_rounded >> LOG2_N);

endmodule

`default_nettype wire

// File: rtl/vernier_avg_accum.sv
// ============================================================================
// Module      : vernier_avg_accum
// Description : Accumulates 2^LOG2_N accepted vernier samples and publishes a
//               rounded mean; aborts with an error after MAX_REJECT rejects.
//               Optional macro VERNIER_AVG_MINMAX_EN adds min/max tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vernier_avg_accum
    import vernier_pkg::*;
#(
    parameter int LOG2_N     = 8,
    parameter int MAX_REJECT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_sample_valid,
    input  logic             i_sample_ok,
    input  logic [PS_W-1:0]  i_sample_ps,
    output logic             o_busy,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [PS_W-1:0]  o_result_mean,
    output logic             o_result_err,
    output logic [REJ_W-1:0] o_result_rejects,
    output logic [PS_W-1:0]  o_result_min,
    output logic [PS_W-1:0]  o_result_max
);

    localparam int SUM_W = PS_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] C_LAST = {CNT_W{1'b1}} >> 1;

    state_t             r_state;
    logic [SUM_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_acc;
    logic [REJ_W-1:0]   r_rej;

    logic [SUM_W-1:0]   w_sum_next;
    logic [REJ_W-1:0]   w_rej_inc;
    logic [PS_W-1:0]    w_mean;
    logic               w_clear;
    logic               w_accept;
    logic               w_reject;
    logic               w_rej_hit;

    assign w_clear  = i_start && ((r_state == ST_IDLE) ||
                                  (r_state == ST_DONE && i_result_ready));
    // Abort wins over a coincident sample.
    assign w_accept = (r_state == ST_ACCUM) && !i_abort && i_sample_valid && i_sample_ok;
    assign w_reject = (r_state == ST_ACCUM) && !i_abort && i_sample_valid && !i_sample_ok;

    assign w_sum_next = r_sum + SUM_W'(i_sample_ps);
    assign w_rej_inc  = (r_rej == {REJ_W{1'b1}}) ? r_rej : r_rej + 1'b1;
    assign w_rej_hit  = (32'(w_rej_inc) == 32'(MAX_REJECT));

    vernier_avg_div #(
        .LOG2_N (LOG2_N)
    ) u_div (
        .i_sum  (w_sum_next),
        .o_mean (w_mean)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sum          <= '0;
            r_acc          <= '0;
            r_rej          <= '0;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
            o_result_mean  <= '0;
            o_result_err   <= 1'b0;
        end else if (w_clear) begin
            r_state        <= ST_ACCUM;
            r_sum          <= '0;
            r_acc          <= '0;
            r_rej          <= '0;
            o_busy         <= 1'b1;
            o_result_valid <= 1'b0;
            o_result_mean  <= '0;
            o_result_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_accept) begin
                        r_sum <= w_sum_next;
                        r_acc <= r_acc + 1'b1;
                        if (r_acc == C_LAST) begin
                            r_state        <= ST_DONE;
                            o_busy         <= 1'b0;
                            o_result_valid <= 1'b1;
                            o_result_mean  <= w_mean;
                            o_result_err   <= 1'b0;
                        end
                    end else if (w_reject) begin
                        r_rej <= w_rej_inc;
                        if (w_rej_hit) begin
                            r_state        <= ST_DONE;
                            o_busy         <= 1'b0;
                            o_result_valid <= 1'b1;
                            o_result_mean  <= '0;
                            o_result_err   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_result_ready) begin
                        r_state        <= ST_IDLE;
                        o_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_result_rejects = r_rej;

`ifdef VERNIER_AVG_MINMAX_EN
    logic [PS_W-1:0] r_min;
    logic [PS_W-1:0] r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= {PS_W{1'b1}};
            r_max <= '0;
        end else if (w_clear) begin
            r_min <= {PS_W{1'b1}};
            r_max <= '0;
        end else if (w_accept) begin
            if (i_sample_ps < r_min) r_min <= i_sample_ps;
            if (i_sample_ps > r_max) r_max <= i_sample_ps;
        end
    end

    assign o_result_min = r_min;
    assign o_result_max = r_max;
`else
    assign o_result_min = {PS_W{1'b1}};
    assign o_result_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vernier_avg_accum.sv
// ============================================================================
// Module      : tb_vernier_avg_accum
// Description : Self-checking bench for vernier_avg_accum (LOG2_N=2,
//               MAX_REJECT=3) against a queue-based measurement model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vernier_avg_accum;

    localparam int LOG2_N  = 2;
    localparam int MAX_REJ = 3;
    localparam int N       = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_sample_valid = 1'b0;
    logic        i_sample_ok = 1'b0;
    logic [15:0] i_sample_ps = '0;
    logic        i_result_ready = 1'b0;
    logic        o_busy;
    logic        o_result_valid;
    logic [15:0] o_result_mean;
    logic        o_result_err;
    logic [15:0] o_result_rejects;
    logic [15:0] o_result_min;
    logic [15:0] o_result_max;

    int checks = 0;
    int errors = 0;

    vernier_avg_accum #(
        .LOG2_N     (LOG2_N),
        .MAX_REJECT (MAX_REJ)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_sample_valid   (i_sample_valid),
        .i_sample_ok      (i_sample_ok),
        .i_sample_ps      (i_sample_ps),
        .o_busy           (o_busy),
        .o_result_valid   (o_result_valid),
        .i_result_ready   (i_result_ready),
        .o_result_mean    (o_result_mean),
        .o_result_err     (o_result_err),
        .o_result_rejects (o_result_rejects),
        .o_result_min     (o_result_min),
        .o_result_max     (o_result_max)
    );

    always #5 clk = ~clk;

    // Measurement model: list of accepted samples plus reject tally.
    logic [15:0] m_acc[$];
    int          m_rej;
    bit          m_done;
    bit          m_err;

    function automatic void m_clear();
        m_acc.delete();
        m_rej  = 0;
        m_done = 0;
        m_err  = 0;
    endfunction

    function automatic void m_sample(input bit ok, input logic [15:0] ps);
        if (m_done) return;
        if (ok) begin
            m_acc.push_back(ps);
            if (m_acc.size() == N) m_done = 1;
        end else begin
            if (m_rej < 65535) m_rej++;
            if (m_rej == MAX_REJ) begin
                m_done = 1;
                m_err  = 1;
            end
        end
    endfunction

    function automatic logic [15:0] m_mean();
        longint s = 0;
        if (m_err) return 16'd0;
        foreach (m_acc[k]) s += m_acc[k];
        return 16'(((s + N / 2) / N) % 65536);
    endfunction

    function automatic logic [15:0] m_min();
        logic [15:0] r = 16'hFFFF;
`ifdef VERNIER_AVG_MINMAX_EN
        foreach (m_acc[k]) if (m_acc[k] < r) r = m_acc[k];
`endif
        return r;
    endfunction

    function automatic logic [15:0] m_max();
        logic [15:0] r = 16'h0000;
`ifdef VERNIER_AVG_MINMAX_EN
        foreach (m_acc[k]) if (m_acc[k] > r) r = m_acc[k];
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit ok, input logic [15:0] ps);
        m_sample(ok, ps);
        i_sample_valid = 1'b1;
        i_sample_ok    = ok;
        i_sample_ps    = ps;
        tick();
        i_sample_valid = 1'b0;
        i_sample_ok    = 1'b0;
        i_sample_ps    = 16'($urandom);
    endtask

    task automatic pulse_start();
        m_clear();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic handshake();
        i_result_ready = 1'b1;
        tick();
        i_result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_result_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b valid=%b err=%b exp 0 0 0", o_busy, o_result_valid, o_result_err);
        end
        checks++;
        if (o_result_mean !== 16'd0 || o_result_rejects !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got mean=%0d rej=%0d exp 0 0", o_result_mean, o_result_rejects);
        end
        checks++;
        if (o_result_min !== 16'hFFFF || o_result_max !== 16'h0000) begin
            errors++;
            $display("FAIL reset_minmax got min=%h max=%h exp ffff 0000", o_result_min, o_result_max);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] vals[4] = '{16'd22, 16'd33, 16'd44, 16'd55};
        pulse_start();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", o_busy);
        end
        for (int k = 0; k < 3; k++) put(1'b1, vals[k]);
        checks++;
        if (o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b exp 0", o_result_valid);
        end
        put(1'b1, vals[3]);
        checks++;
        if (o_result_valid !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid got valid=%b busy=%b exp 1 0", o_result_valid, o_busy);
        end
        checks++;
        if (o_result_mean !== 16'd39 || o_result_mean !== m_mean()) begin
            errors++;
            $display("FAIL basic_mean got %0d exp %0d", o_result_mean, m_mean());
        end
        checks++;
        if (o_result_rejects !== 16'd0 || o_result_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_rej got rej=%0d err=%b exp 0 0", o_result_rejects, o_result_err);
        end
        checks++;
        if (o_result_min !== m_min() || o_result_max !== m_max()) begin
            errors++;
            $display("FAIL basic_minmax got %0d/%0d exp %0d/%0d", o_result_min, o_result_max, m_min(), m_max());
        end
        handshake();
        checks++;
        if (o_result_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release got valid=%b busy=%b exp 0 0", o_result_valid, o_busy);
        end
    endtask

    task automatic test_rejects();
        pulse_start();
        put(1'b0, 16'd11);
        put(1'b1, 16'd110);
        put(1'b0, 16'($urandom));
        put(1'b1, 16'd22);
        i_start = 1'b1;
        put(1'b1, 16'd33);
        i_start = 1'b0;
        put(1'b1, 16'd44);
        checks++;
        if (o_result_valid !== 1'b1 || o_result_mean !== 16'd52 || o_result_mean !== m_mean()) begin
            errors++;
            $display("FAIL rej_mean got valid=%b mean=%0d exp 1 %0d", o_result_valid, o_result_mean, m_mean());
        end
        checks++;
        if (o_result_rejects !== 16'd2 || o_result_err !== 1'b0) begin
            errors++;
            $display("FAIL rej_count got rej=%0d err=%b exp 2 0", o_result_rejects, o_result_err);
        end
        handshake();
    endtask

    task automatic test_err_hold();
        pulse_start();
        put(1'b0, 16'd5);
        put(1'b0, 16'd6);
        checks++;
        if (o_result_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL err_early got valid=%b busy=%b exp 0 1", o_result_valid, o_busy);
        end
        put(1'b0, 16'd7);
        checks++;
        if (o_result_valid !== 1'b1 || o_result_err !== 1'b1 || o_result_mean !== 16'd0 || o_result_rejects !== 16'd3) begin
            errors++;
            $display("FAIL err_result got valid=%b err=%b mean=%0d rej=%0d exp 1 1 0 3",
                     o_result_valid, o_result_err, o_result_mean, o_result_rejects);
        end
        // DONE must ignore start, abort and samples while ready is low.
        for (int k = 0; k < 10; k++) begin
            i_start        = (k % 3 == 0);
            i_abort        = (k % 4 == 1);
            i_sample_valid = 1'b1;
            i_sample_ok    = k[0];
            i_sample_ps    = 16'($urandom);
            tick();
            checks++;
            if (o_result_valid !== 1'b1 || o_result_err !== 1'b1 || o_result_mean !== 16'd0 ||
                o_result_rejects !== 16'd3 || o_busy !== 1'b0 ||
                o_result_min !== 16'hFFFF || o_result_max !== 16'h0000) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got valid=%b err=%b mean=%0d rej=%0d busy=%b min=%h max=%h",
                         k, o_result_valid, o_result_err, o_result_mean, o_result_rejects, o_busy,
                         o_result_min, o_result_max);
            end
        end
        i_abort        = 1'b0;
        i_sample_valid = 1'b0;
        i_start        = 1'b1;
        i_result_ready = 1'b1;
        m_clear();
        tick();
        i_start        = 1'b0;
        i_result_ready = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_result_valid !== 1'b0 || o_result_rejects !== 16'd0 || o_result_err !== 1'b0) begin
            errors++;
            $display("FAIL restart got busy=%b valid=%b rej=%0d err=%b exp 1 0 0 0",
                     o_busy, o_result_valid, o_result_rejects, o_result_err);
        end
        for (int k = 0; k < N; k++) put(1'b1, 16'd100 + 16'(k));
        checks++;
        if (o_result_valid !== 1'b1 || o_result_mean !== m_mean() || o_result_rejects !== 16'd0) begin
            errors++;
            $display("FAIL restart_result got valid=%b mean=%0d rej=%0d exp 1 %0d 0",
                     o_result_valid, o_result_mean, o_result_rejects, m_mean());
        end
        handshake();
    endtask

    task automatic test_abort();
        pulse_start();
        put(1'b1, 16'd500);
        put(1'b1, 16'd600);
        i_abort = 1'b1;
        put(1'b1, 16'd700);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b valid=%b exp 0 0", o_busy, o_result_valid);
        end
        // Samples after abort are outside ACCUM and must not complete anything.
        for (int k = 0; k < 3; k++) put(1'b1, 16'd800);
        checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_stay got busy=%b valid=%b exp 0 0", o_busy, o_result_valid);
        end
        pulse_start();
        for (int k = 0; k < N; k++) put(1'b1, 16'd1320);
        checks++;
        if (o_result_valid !== 1'b1 || o_result_mean !== 16'd1320) begin
            errors++;
            $display("FAIL abort_next got valid=%b mean=%0d exp 1 1320", o_result_valid, o_result_mean);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        pulse_start();
        put(1'b0, 16'd9);
        put(1'b1, 16'd40);
        put(1'b1, 16'd50);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_result_rejects !== 16'd0 ||
            o_result_mean !== 16'd0 || o_result_err !== 1'b0 ||
            o_result_min !== 16'hFFFF || o_result_max !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid got busy=%b valid=%b rej=%0d mean=%0d err=%b min=%h max=%h",
                     o_busy, o_result_valid, o_result_rejects, o_result_mean, o_result_err,
                     o_result_min, o_result_max);
        end
        #3;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) put(k[0], 16'd60000);
        checks++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_result_rejects !== 16'd0) begin
            errors++;
            $display("FAIL idle_samples got busy=%b valid=%b rej=%0d exp 0 0 0", o_busy, o_result_valid, o_result_rejects);
        end
        pulse_start();
        for (int k = 0; k < N; k++) put(1'b1, 16'd7);
        checks++;
        if (o_result_valid !== 1'b1 || o_result_mean !== 16'd7) begin
            errors++;
            $display("FAIL post_reset got valid=%b mean=%0d exp 1 7", o_result_valid, o_result_mean);
        end
        handshake();
    endtask

    task automatic test_random();
        bit in_accum = 0;
        int cyc;
        for (int t = 0; t < 40; t++) begin
            if (!in_accum) pulse_start();
            cyc = 0;
            while (!m_done && cyc < 200) begin
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                end else begin
                    checks++;
                    if (o_result_valid !== 1'b0 || o_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_busy iter %0d got valid=%b busy=%b exp 0 1", t, o_result_valid, o_busy);
                    end
                    if (t % 5 == 0)
                        put($urandom_range(0, 3) != 0, 16'($urandom_range(65000, 65535)));
                    else
                        put($urandom_range(0, 3) != 0, 16'($urandom));
                end
                cyc++;
            end
            checks++;
            if (!m_done) begin
                errors++;
                $display("FAIL rand_timeout iter %0d got no completion exp done", t);
            end
            checks++;
            if (o_result_valid !== 1'b1 || o_result_err !== m_err || o_result_mean !== m_mean() ||
                o_result_rejects !== 16'(m_rej) || o_result_min !== m_min() || o_result_max !== m_max()) begin
                errors++;
                $display("FAIL rand_result iter %0d got v=%b err=%b mean=%0d rej=%0d min=%0d max=%0d exp 1 %b %0d %0d %0d %0d",
                         t, o_result_valid, o_result_err, o_result_mean, o_result_rejects, o_result_min,
                         o_result_max, m_err, m_mean(), m_rej, m_min(), m_max());
            end
            repeat ($urandom_range(0, 3)) tick();
            in_accum = ($urandom_range(0, 1) == 1);
            i_start        = in_accum;
            i_result_ready = 1'b1;
            if (in_accum) m_clear();
            tick();
            i_start        = 1'b0;
            i_result_ready = 1'b0;
            checks++;
            if (o_result_valid !== 1'b0 || o_busy !== in_accum) begin
                errors++;
                $display("FAIL rand_release iter %0d got valid=%b busy=%b exp 0 %b", t, o_result_valid, o_busy, in_accum);
            end
        end
        if (in_accum) begin
            i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rejects();
        test_err_hold();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
